// File: rtl/uart_rx_frame_if.sv
// Receive-side word handshake between uart_rx_frame (master) and its consumer (slave).
interface uart_rx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  frame_err;
  logic                  parity_err;
  logic                  overrun;

  modport master (
    output rx_data, rx_valid, frame_err, parity_err, overrun,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, frame_err, parity_err, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_frame.sv
// UART frame receiver: 2-flop sync, mid-bit sampling, LSB-first deserialiser, stop check,
// one-word holding register. Define UART_RX_PARITY_EN to add a parity bit after the data.
module uart_rx_frame #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic              busy,
  uart_rx_frame_if.master   rx_bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  ferr;
    logic                  perr;
  } rx_word_t;

  state_t                state, state_nxt;
  logic                  rx_meta, rx_s, rx_prev;
  logic [CW-1:0]         cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  ferr;
  logic                  fall, mid, tick, smp, done;
  rx_word_t              word, hold;
  logic                  hold_vld, ovr;

  // rx_prev is the edge-detect history; it idles high like the line
  always_ff @(posedge clk) begin
    if (reset) {rx_meta, rx_s, rx_prev} <= 3'b111;
    else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;
  assign mid  = (cnt == MID);
  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (fall) state_nxt = START;
      START: if (mid)  state_nxt = rx_s ? IDLE : DATA;
      DATA:  if (tick && bit_cnt == BW'(DATA_WIDTH - 1))
`ifdef UART_RX_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = STOP;
`endif
      PARITY: if (tick) state_nxt = STOP;
      STOP:  if (tick && bit_cnt == BW'(STOP_BITS - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    smp  = 1'b0;
    done = 1'b0;
    case (state)
      DATA, PARITY: begin busy = 1'b1; smp = tick; end
      STOP: begin
        busy = 1'b1;
        smp  = tick;
        done = tick && (bit_cnt == BW'(STOP_BITS - 1));
      end
      default: ;
    endcase
  end

  // Bit-period counter and per-state sample count both restart on any state change,
  // so each sample lands a whole bit period after the start mid-point.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      ferr    <= 1'b0;
    end else begin
      if (state_nxt != state) begin
        cnt     <= '0;
        bit_cnt <= '0;
      end else begin
        cnt <= tick ? '0 : cnt + 1'b1;
        if (smp) bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == DATA && smp)         shreg <= {rx_s, shreg[DATA_WIDTH-1:1]};
      if (state == STOP && smp && !rx_s) ferr <= 1'b1;
      if (state == IDLE && fall)        ferr <= 1'b0;
    end
  end

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = PARITY_ODD[0];
  logic par_bit;

  always_ff @(posedge clk) begin
    if (reset)                      par_bit <= 1'b0;
    else if (state == PARITY && smp) par_bit <= rx_s;
  end

  assign word.perr = ^shreg ^ par_bit ^ PAR_SENSE;
`else
  logic unused_par;
  assign unused_par = ^PARITY_ODD;
  assign word.perr  = 1'b0;
`endif

  // The final stop sample is folded in here since it is taken on the completing edge.
  assign word.data = shreg;
  assign word.ferr = ferr | ~rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold     <= '0;
      hold_vld <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      ovr <= 1'b0;
      if (done) begin
        if (!hold_vld || rx_bus.rx_ready) begin
          hold     <= word;
          hold_vld <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end else if (hold_vld && rx_bus.rx_ready) begin
        hold_vld <= 1'b0;
      end
    end
  end

  assign rx_bus.rx_data    = hold.data;
  assign rx_bus.frame_err  = hold.ferr;
  assign rx_bus.parity_err = hold.perr;
  assign rx_bus.rx_valid   = hold_vld;
  assign rx_bus.overrun    = ovr;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: 8N1 instance plus a 5-bit / 2-stop instance.
module tb_uart_rx_frame;
  localparam int C = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1;
  logic busy0, busy1;
  int   checks = 0, passed = 0, fails = 0;

  uart_rx_frame_if #(.DATA_WIDTH(8)) b0 ();
  uart_rx_frame_if #(.DATA_WIDTH(5)) b1 ();

  uart_rx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(C), .STOP_BITS(1), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .rx(rx0), .busy(busy0), .rx_bus(b0));
  uart_rx_frame #(.DATA_WIDTH(5), .CLKS_PER_BIT(C), .STOP_BITS(2), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .rx(rx1), .busy(busy1), .rx_bus(b1));

  always #5 clk = ~clk;

  // Event monitor, sampled on the falling edge
  int cyc = 0;
  int acc_cnt = 0, ovr_cnt = 0, busy_cnt = 0, acc1_cnt = 0;
  int vrise_cyc = -1, bfall_cyc = -2;
  logic [7:0] acc_data = '0;
  logic [4:0] acc1_data = '0;
  logic acc_ferr = 0, acc_perr = 0, acc1_ferr = 0;
  logic valid_q = 0, busy_q = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (b0.rx_valid && b0.rx_ready) begin
      acc_cnt++; acc_data = b0.rx_data; acc_ferr = b0.frame_err; acc_perr = b0.parity_err;
    end
    if (b1.rx_valid && b1.rx_ready) begin
      acc1_cnt++; acc1_data = b1.rx_data; acc1_ferr = b1.frame_err;
    end
    if (b0.overrun) ovr_cnt++;
    if (busy0) busy_cnt++;
    if (b0.rx_valid && !valid_q) vrise_cyc = cyc;
    if (!busy0 && busy_q) bfall_cyc = cyc;
    valid_q = b0.rx_valid;
    busy_q  = busy0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) rx1 = v; else rx0 = v;
    tick(n);
  endtask

  function automatic logic epar(input logic [8:0] d, input int dw);
    logic p = 1'b0;
    for (int i = 0; i < dw; i++) p ^= d[i];
    return p;
  endfunction

  task automatic send_frame(input bit sel, input logic [8:0] d, input int dw, input int nstop,
                            input logic stop0, input logic stop1, input logic par);
    drive(sel, 1'b0, C);
    for (int i = 0; i < dw; i++) drive(sel, d[i], C);
`ifdef UART_RX_PARITY_EN
    drive(sel, par, C);
`else
    if (par === 1'bx) drive(sel, 1'b1, 1);
`endif
    drive(sel, stop0, C);
    if (nstop > 1) drive(sel, stop1, C);
    if (sel) rx1 = 1'b1; else rx0 = 1'b1;
  endtask

  int base;

  initial begin
    b0.rx_ready = 1'b1;
    b1.rx_ready = 1'b1;
    tick(4);
    chk("rst_data",  b0.rx_data, 0);
    chk("rst_valid", b0.rx_valid, 0);
    chk("rst_busy",  busy0, 0);
    chk("rst_ferr",  b0.frame_err, 0);
    chk("rst_perr",  b0.parity_err, 0);
    chk("rst_ovr",   b0.overrun, 0);
    chk("rst1_valid", b1.rx_valid, 0);
    chk("rst1_data",  b1.rx_data, 0);
    reset = 1'b0;
    tick(2 * C);

    // Clean frame 0xA5
    base = acc_cnt;
    send_frame(0, 9'h0A5, 8, 1, 1'b1, 1'b1, epar(9'h0A5, 8));
    tick(C);
    chk("clean_cnt",   acc_cnt - base, 1);
    chk("clean_data",  acc_data, 8'hA5);
    chk("clean_ferr",  acc_ferr, 0);
    chk("clean_busy_edge", vrise_cyc, bfall_cyc);
    chk("clean_valid_clr", b0.rx_valid, 0);

    // Glitch: 5 low cycles must not start a frame
    busy_cnt = 0;
    base = acc_cnt;
    drive(0, 1'b0, 5);
    drive(0, 1'b1, 3 * C);
    chk("glitch_busy",  busy_cnt, 0);
    chk("glitch_valid", b0.rx_valid, 0);
    chk("glitch_cnt",   acc_cnt - base, 0);

    // Framing error: 0x3C with stop bit 0, held for inspection
    b0.rx_ready = 1'b0;
    send_frame(0, 9'h03C, 8, 1, 1'b0, 1'b1, epar(9'h03C, 8));
    tick(C);
    chk("ferr_valid", b0.rx_valid, 1);
    chk("ferr_data",  b0.rx_data, 8'h3C);
    chk("ferr_flag",  b0.frame_err, 1);
    b0.rx_ready = 1'b1;
    tick(2);
    chk("ferr_clr", b0.rx_valid, 0);

    // Break: line low for 20 bit times yields one zero word with frame_err
    base = acc_cnt;
    drive(0, 1'b0, 20 * C);
    chk("brk_cnt",  acc_cnt - base, 1);
    chk("brk_data", acc_data, 8'h00);
    chk("brk_ferr", acc_ferr, 1);
    chk("brk_busy", busy0, 0);
    drive(0, 1'b1, 2 * C);
    chk("brk_noretrig", acc_cnt - base, 1);

    // Backpressure: second frame dropped with one overrun pulse
    b0.rx_ready = 1'b0;
    base = ovr_cnt;
    send_frame(0, 9'h011, 8, 1, 1'b1, 1'b1, epar(9'h011, 8));
    tick(C);
    send_frame(0, 9'h022, 8, 1, 1'b1, 1'b1, epar(9'h022, 8));
    tick(C);
    chk("ovr_pulses", ovr_cnt - base, 1);
    chk("ovr_data",   b0.rx_data, 8'h11);
    chk("ovr_valid",  b0.rx_valid, 1);
    chk("ovr_ferr",   b0.frame_err, 0);
    b0.rx_ready = 1'b1;
    tick(2);
    chk("ovr_clr", b0.rx_valid, 0);

    // Parity on 0x07 (three ones): bit 1 is good even parity, bit 0 is bad
    base = acc_cnt;
    send_frame(0, 9'h007, 8, 1, 1'b1, 1'b1, 1'b1);
    tick(C);
    chk("par_good", acc_perr, 0);
    send_frame(0, 9'h007, 8, 1, 1'b1, 1'b1, 1'b0);
    tick(C);
`ifdef UART_RX_PARITY_EN
    chk("par_bad", acc_perr, 1);
`else
    chk("par_off", acc_perr, 0);
`endif
    chk("par_cnt",  acc_cnt - base, 2);
    chk("par_data", acc_data, 8'h07);

    // Reset in the middle of bit 4 of 0xFF, with a word held
    b0.rx_ready = 1'b0;
    send_frame(0, 9'h03C, 8, 1, 1'b1, 1'b1, epar(9'h03C, 8));
    tick(C);
    chk("pre_rst_valid", b0.rx_valid, 1);
    drive(0, 1'b0, C);
    for (int i = 0; i < 4; i++) drive(0, 1'b1, C);
    drive(0, 1'b1, C / 2);
    chk("pre_rst_busy", busy0, 1);
    reset = 1'b1;
    tick(2);
    chk("mrst_data",  b0.rx_data, 0);
    chk("mrst_valid", b0.rx_valid, 0);
    chk("mrst_busy",  busy0, 0);
    chk("mrst_ferr",  b0.frame_err, 0);
    chk("mrst_ovr",   b0.overrun, 0);
    reset = 1'b0;
    b0.rx_ready = 1'b1;
    tick(2 * C);
    base = acc_cnt;
    send_frame(0, 9'h05A, 8, 1, 1'b1, 1'b1, epar(9'h05A, 8));
    tick(C);
    chk("post_rst_cnt",  acc_cnt - base, 1);
    chk("post_rst_data", acc_data, 8'h5A);
    chk("post_rst_ferr", acc_ferr, 0);

    // 5 data bits, 2 stop bits
    base = acc1_cnt;
    send_frame(1, 9'h015, 5, 2, 1'b1, 1'b1, epar(9'h015, 5));
    tick(C);
    chk("w5_cnt",  acc1_cnt - base, 1);
    chk("w5_data", acc1_data, 5'h15);
    chk("w5_ferr", acc1_ferr, 0);
    send_frame(1, 9'h00A, 5, 2, 1'b1, 1'b0, epar(9'h00A, 5));
    tick(C);
    chk("w5_stop2_data", acc1_data, 5'h0A);
    chk("w5_stop2_ferr", acc1_ferr, 1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
